// File: rtl/icache_pkg.sv
// icache_pkg: shared types and width helpers for the instruction-cache fill
// controller and its line storage.
//   state_t - fill controller states (IDLE, REQ, WAIT)
//   line_t  - one cache line {valid, tag, data}; the tag field is sized for
//             the smallest legal index width and holds zero-extended tags
package icache_pkg;

    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned DATA_W    = 32;
    // Smallest index width is 1 bit (NUM_LINES = 2), giving the widest tag.
    localparam int unsigned TAG_W_MAX = ADDR_W - 2 - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    typedef struct packed {
        logic                 valid;
        logic [TAG_W_MAX-1:0] tag;
        logic [DATA_W-1:0]    data;
    } line_t;

    function automatic int unsigned idx_bits(input int unsigned num_lines);
        return $clog2(num_lines);
    endfunction

    function automatic int unsigned tag_bits(input int unsigned num_lines);
        return ADDR_W - 2 - $clog2(num_lines);
    endfunction

endpackage

// File: rtl/icache_fill_ctrl_array.sv
// icache_array: direct-mapped line storage, one word per line.
//   clk, rst      - clock; asynchronous active-high reset clears valid bits
//   i_flash_clr   - synchronous clear of every valid bit (beats a write)
//   i_rd_idx      - combinational read index
//   o_rd_line     - line at i_rd_idx
//   i_wr_en       - write tag/data at i_wr_idx and mark the line valid
//   i_wr_idx, i_wr_tag, i_wr_data - write port contents
module icache_array
    import icache_pkg::*;
#(
    parameter int unsigned NUM_LINES = 32,
    parameter int unsigned IDX_BITS  = $clog2(NUM_LINES)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_flash_clr,
    input  logic [IDX_BITS-1:0]  i_rd_idx,
    output line_t                o_rd_line,
    input  logic                 i_wr_en,
    input  logic [IDX_BITS-1:0]  i_wr_idx,
    input  logic [TAG_W_MAX-1:0] i_wr_tag,
    input  logic [DATA_W-1:0]    i_wr_data
);

    logic [NUM_LINES-1:0] r_valid;
    logic [TAG_W_MAX-1:0] r_tag  [NUM_LINES];
    logic [DATA_W-1:0]    r_data [NUM_LINES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
        end else if (i_flash_clr) begin
            r_valid <= '0;
        end else if (i_wr_en) begin
            r_valid[i_wr_idx] <= 1'b1;
        end
    end

    // Tag/data need no reset: they are only observed through r_valid.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_tag[i_wr_idx]  <= i_wr_tag;
            r_data[i_wr_idx] <= i_wr_data;
        end
    end

    always_comb begin
        o_rd_line       = '0;
        o_rd_line.valid = r_valid[i_rd_idx];
        o_rd_line.tag   = r_tag[i_rd_idx];
        o_rd_line.data  = r_data[i_rd_idx];
    end

endmodule

// File: rtl/icache_fill_ctrl.sv
// icache_fill_ctrl: instruction-side cache responder for the fetch stage.
// Hits return the word combinationally; misses run a req/ack/response fill
// to backing memory and forward the returned word when the fetch address
// still matches.
//   clk, rst                          - clock, async active-high reset
//   proc2Imem_addr                    - fetch address (bits [1:0] ignored)
//   Imem2proc_data / Imem2proc_valid  - instruction word and its valid flag
//   invalidate                        - synchronous flush of all lines
//   proc2mem_req / proc2mem_addr      - miss request, held until ack
//   mem2proc_ack                      - memory accepted the request
//   mem2proc_data / mem2proc_valid    - fill response (honoured in WAIT)
module icache_fill_ctrl
    import icache_pkg::*;
#(
    parameter int unsigned NUM_LINES = 32,
    parameter int unsigned IDX_BITS  = $clog2(NUM_LINES)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] proc2Imem_addr,
    output logic [31:0] Imem2proc_data,
    output logic        Imem2proc_valid,
    input  logic        invalidate,
    output logic        proc2mem_req,
    output logic [31:0] proc2mem_addr,
    input  logic        mem2proc_ack,
    input  logic [31:0] mem2proc_data,
    input  logic        mem2proc_valid
);

    localparam int unsigned TAG_BITS = tag_bits(NUM_LINES);

    state_t               r_state;
    logic                 r_req;
    logic [31:0]          r_miss_addr;
    logic                 r_drop;

    logic [31:0]          w_fetch_aligned;
    logic [IDX_BITS-1:0]  w_rd_idx;
    logic [TAG_W_MAX-1:0] w_rd_tag;
    logic [IDX_BITS-1:0]  w_wr_idx;
    logic [TAG_W_MAX-1:0] w_wr_tag;
    line_t                w_rd_line;
    logic                 w_hit;
    logic                 w_fwd;
    logic                 w_fill_done;
    logic                 w_fill_we;
    logic                 w_unused_lsb;

    assign w_unused_lsb    = ^proc2Imem_addr[1:0];
    assign w_fetch_aligned = {proc2Imem_addr[31:2], 2'b00};
    assign w_rd_idx        = proc2Imem_addr[IDX_BITS+1:2];
    assign w_wr_idx        = r_miss_addr[IDX_BITS+1:2];

    always_comb begin
        w_rd_tag = '0;
        w_rd_tag[TAG_BITS-1:0] = proc2Imem_addr[31:IDX_BITS+2];
        w_wr_tag = '0;
        w_wr_tag[TAG_BITS-1:0] = r_miss_addr[31:IDX_BITS+2];
    end

    icache_array #(
        .NUM_LINES (NUM_LINES),
        .IDX_BITS  (IDX_BITS)
    ) u_array (
        .clk         (clk),
        .rst         (rst),
        .i_flash_clr (invalidate),
        .i_rd_idx    (w_rd_idx),
        .o_rd_line   (w_rd_line),
        .i_wr_en     (w_fill_we),
        .i_wr_idx    (w_wr_idx),
        .i_wr_tag    (w_wr_tag),
        .i_wr_data   (mem2proc_data)
    );

    assign w_hit       = w_rd_line.valid && (w_rd_line.tag == w_rd_tag);
    assign w_fill_done = (r_state == WAIT) && mem2proc_valid;
    assign w_fwd       = w_fill_done && (w_fetch_aligned == r_miss_addr);
    // A flush pending (r_drop) or arriving this cycle suppresses the install.
    assign w_fill_we   = w_fill_done && !r_drop && !invalidate;

    always_comb begin
        Imem2proc_valid = w_hit || w_fwd;
        Imem2proc_data  = '0;
        if (w_hit) begin
            Imem2proc_data = w_rd_line.data;
        end else if (w_fwd) begin
            Imem2proc_data = mem2proc_data;
        end
    end

    // The miss address register doubles as proc2mem_addr: it only changes
    // when a new miss is launched, so it is stable for the whole request.
    assign proc2mem_req  = r_req;
    assign proc2mem_addr = r_miss_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_req       <= 1'b0;
            r_miss_addr <= '0;
            r_drop      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!w_hit) begin
                        r_miss_addr <= w_fetch_aligned;
                        r_req       <= 1'b1;
                        r_state     <= REQ;
                    end
                end
                REQ: begin
                    if (invalidate) begin
                        r_drop <= 1'b1;
                    end
                    if (mem2proc_ack) begin
                        r_req   <= 1'b0;
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem2proc_valid) begin
                        r_drop  <= 1'b0;
                        r_state <= IDLE;
                    end else if (invalidate) begin
                        r_drop <= 1'b1;
                    end
                end
                default: begin
                    r_req   <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Bench for icache_fill_ctrl: directed scenarios followed by randomized
// traffic, all checked every cycle against a transaction-level model that
// keeps the cache as per-line {valid, word address, word}.
module tb_icache_fill_ctrl;

    localparam int unsigned NL = 32;

    logic        clk;
    logic        rst;
    logic [31:0] proc2Imem_addr;
    logic [31:0] Imem2proc_data;
    logic        Imem2proc_valid;
    logic        invalidate;
    logic        proc2mem_req;
    logic [31:0] proc2mem_addr;
    logic        mem2proc_ack;
    logic [31:0] mem2proc_data;
    logic        mem2proc_valid;

    icache_fill_ctrl #(.NUM_LINES(NL)) dut (
        .clk             (clk),
        .rst             (rst),
        .proc2Imem_addr  (proc2Imem_addr),
        .Imem2proc_data  (Imem2proc_data),
        .Imem2proc_valid (Imem2proc_valid),
        .invalidate      (invalidate),
        .proc2mem_req    (proc2mem_req),
        .proc2mem_addr   (proc2mem_addr),
        .mem2proc_ack    (mem2proc_ack),
        .mem2proc_data   (mem2proc_data),
        .mem2proc_valid  (mem2proc_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model
    bit          m_vld   [NL];
    logic [31:0] m_waddr [NL];
    logic [31:0] m_word  [NL];
    bit          m_pend;
    bit          m_acked;
    bit          m_drop;
    logic [31:0] m_addr;
    logic [31:0] m_req_addr;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned n_fail   = 0;
    string       g_phase  = "init";

    function automatic int unsigned line_of(input logic [31:0] a);
        return (a / 4) % NL;
    endfunction

    function automatic logic [31:0] align(input logic [31:0] a);
        return (a / 4) * 4;
    endfunction

    function automatic bit m_hit(input logic [31:0] a);
        return m_vld[line_of(a)] && (m_waddr[line_of(a)] == align(a));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < int'(NL); i++) m_vld[i] = 1'b0;
        m_pend     = 1'b0;
        m_acked    = 1'b0;
        m_drop     = 1'b0;
        m_addr     = '0;
        m_req_addr = '0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s:%s observed=%h expected=%h", g_phase, tag, obs, exp);
        end
    endtask

    // Compare all outputs against the model just before the next edge.
    task automatic look();
        bit          hit;
        bit          fwd;
        logic [31:0] exp_d;
        @(negedge clk);
        hit   = !rst && m_hit(proc2Imem_addr);
        fwd   = !rst && m_pend && m_acked && mem2proc_valid &&
                (align(proc2Imem_addr) == m_addr);
        exp_d = hit ? m_word[line_of(proc2Imem_addr)] : (fwd ? mem2proc_data : 32'h0);
        chk("valid",    {31'b0, Imem2proc_valid}, {31'b0, hit || fwd});
        chk("data",     Imem2proc_data, exp_d);
        chk("req",      {31'b0, proc2mem_req}, {31'b0, m_pend && !m_acked});
        chk("req_addr", proc2mem_addr, m_req_addr);
        chk("addr_lsb", {30'b0, proc2mem_addr[1:0]}, 32'h0);
    endtask

    // Advance the model across one clock edge using the held inputs.
    task automatic tick();
        bit          hit;
        int unsigned ln;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            hit = m_hit(proc2Imem_addr);
            if (!m_pend) begin
                if (!hit) begin
                    m_pend     = 1'b1;
                    m_acked    = 1'b0;
                    m_addr     = align(proc2Imem_addr);
                    m_req_addr = align(proc2Imem_addr);
                end
            end else if (!m_acked) begin
                if (invalidate)   m_drop  = 1'b1;
                if (mem2proc_ack) m_acked = 1'b1;
            end else begin
                if (mem2proc_valid) begin
                    if (!m_drop && !invalidate) begin
                        ln          = line_of(m_addr);
                        m_vld[ln]   = 1'b1;
                        m_waddr[ln] = m_addr;
                        m_word[ln]  = mem2proc_data;
                    end
                    m_pend = 1'b0;
                    m_drop = 1'b0;
                end else if (invalidate) begin
                    m_drop = 1'b1;
                end
            end
            if (invalidate) begin
                for (int i = 0; i < int'(NL); i++) m_vld[i] = 1'b0;
            end
        end
        #1;
    endtask

    task automatic step();
        look();
        tick();
    endtask

    // Minimum-latency fill of an address that is known to miss.
    task automatic fill(input logic [31:0] a, input logic [31:0] d);
        proc2Imem_addr = a;
        step();
        mem2proc_ack = 1'b1;
        step();
        mem2proc_ack   = 1'b0;
        mem2proc_valid = 1'b1;
        mem2proc_data  = d;
        step();
        mem2proc_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst_req_async", {31'b0, proc2mem_req}, 32'h0);
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst            = 1'b0;
        proc2Imem_addr = '0;
        invalidate     = 1'b0;
        mem2proc_ack   = 1'b0;
        mem2proc_data  = '0;
        mem2proc_valid = 1'b0;
        model_reset();
        #1 rst = 1'b1;
        #1;
        g_phase = "reset";
        chk("valid",    {31'b0, Imem2proc_valid}, 32'h0);
        chk("data",     Imem2proc_data, 32'h0);
        chk("req",      {31'b0, proc2mem_req}, 32'h0);
        chk("req_addr", proc2mem_addr, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // 1: first miss, minimum latency, forward then hit
        g_phase = "t1";
        proc2Imem_addr = 32'h0;
        look();
        chk("miss_valid", {31'b0, Imem2proc_valid}, 32'h0);
        tick();
        mem2proc_ack = 1'b1;
        look();
        chk("req_up", {31'b0, proc2mem_req}, 32'h1);
        chk("req_addr0", proc2mem_addr, 32'h0);
        tick();
        mem2proc_ack   = 1'b0;
        mem2proc_valid = 1'b1;
        mem2proc_data  = 32'hDEADBEEF;
        look();
        chk("fwd_valid", {31'b0, Imem2proc_valid}, 32'h1);
        chk("fwd_data", Imem2proc_data, 32'hDEADBEEF);
        tick();
        mem2proc_valid = 1'b0;
        look();
        chk("hit_data", Imem2proc_data, 32'hDEADBEEF);
        chk("hit_noreq", {31'b0, proc2mem_req}, 32'h0);
        tick();

        // 2: conflict eviction at line 0
        g_phase = "t2";
        do_reset();
        fill(32'h0, 32'h11111111);
        fill(32'h80, 32'h22222222);
        proc2Imem_addr = 32'h80;
        look();
        chk("hit80", Imem2proc_data, 32'h22222222);
        tick();
        proc2Imem_addr = 32'h0;
        look();
        chk("evicted0", {31'b0, Imem2proc_valid}, 32'h0);
        tick();
        mem2proc_ack = 1'b1;
        look();
        chk("rereq", {31'b0, proc2mem_req}, 32'h1);
        chk("rereq_addr", proc2mem_addr, 32'h0);
        tick();
        mem2proc_ack   = 1'b0;
        mem2proc_valid = 1'b1;
        mem2proc_data  = 32'h33333333;
        step();
        mem2proc_valid = 1'b0;

        // 3: redirect while the fill is outstanding
        g_phase = "t3";
        proc2Imem_addr = 32'h10;
        step();
        mem2proc_ack = 1'b1;
        step();
        mem2proc_ack   = 1'b0;
        proc2Imem_addr = 32'h14;
        step();
        mem2proc_valid = 1'b1;
        mem2proc_data  = 32'hAAAA0010;
        look();
        chk("no_fwd", {31'b0, Imem2proc_valid}, 32'h0);
        tick();
        mem2proc_valid = 1'b0;
        look();
        chk("idle_noreq", {31'b0, proc2mem_req}, 32'h0);
        tick();
        mem2proc_ack = 1'b1;
        look();
        chk("req14", proc2mem_addr, 32'h14);
        tick();
        mem2proc_ack   = 1'b0;
        mem2proc_valid = 1'b1;
        mem2proc_data  = 32'hAAAA0014;
        step();
        mem2proc_valid = 1'b0;
        proc2Imem_addr = 32'h10;
        look();
        chk("hit10", Imem2proc_data, 32'hAAAA0010);
        tick();

        // 4: invalidate while waiting for the response
        g_phase = "t4";
        proc2Imem_addr = 32'h20;
        step();
        mem2proc_ack = 1'b1;
        step();
        mem2proc_ack = 1'b0;
        invalidate   = 1'b1;
        step();
        invalidate     = 1'b0;
        mem2proc_valid = 1'b1;
        mem2proc_data  = 32'hBBBB0020;
        look();
        chk("fwd_dropped", Imem2proc_data, 32'hBBBB0020);
        tick();
        mem2proc_valid = 1'b0;
        look();
        chk("not_installed", {31'b0, Imem2proc_valid}, 32'h0);
        tick();
        mem2proc_ack = 1'b1;
        look();
        chk("rereq20", proc2mem_addr, 32'h20);
        tick();
        mem2proc_ack   = 1'b0;
        mem2proc_valid = 1'b1;
        mem2proc_data  = 32'hBBBB0021;
        step();
        mem2proc_valid = 1'b0;

        // 5: reset in the middle of a request
        g_phase = "t5";
        proc2Imem_addr = 32'h40;
        step();
        rst = 1'b1;
        #1;
        model_reset();
        chk("async_req_drop", {31'b0, proc2mem_req}, 32'h0);
        step();
        rst            = 1'b0;
        mem2proc_valid = 1'b1;
        mem2proc_data  = 32'h55555555;
        look();
        chk("late_valid_ign", {31'b0, Imem2proc_valid}, 32'h0);
        tick();
        mem2proc_valid = 1'b0;
        mem2proc_ack   = 1'b1;
        look();
        chk("req40", proc2mem_addr, 32'h40);
        tick();
        mem2proc_ack   = 1'b0;
        mem2proc_valid = 1'b1;
        mem2proc_data  = 32'h40404040;
        step();
        mem2proc_valid = 1'b0;

        // 6: unaligned fetch after an aligned fill
        g_phase = "t6";
        do_reset();
        fill(32'h10, 32'hCAFEF00D);
        proc2Imem_addr = 32'h13;
        look();
        chk("unaligned_hit", Imem2proc_data, 32'hCAFEF00D);
        tick();

        // Randomized traffic over a small address pool to force hits,
        // conflicts, redirects, flushes and resets.
        g_phase = "rand";
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) < 2) begin
                do_reset();
            end else begin
                if ($urandom_range(0, 3) == 0) begin
                    proc2Imem_addr = ($urandom_range(0, 3) << 7) |
                                     ($urandom_range(0, 7) << 2) |
                                     $urandom_range(0, 3);
                end
                mem2proc_ack   = 1'($urandom_range(0, 1));
                mem2proc_valid = (m_pend && m_acked) ? ($urandom_range(0, 2) != 0)
                                                     : ($urandom_range(0, 9) == 0);
                mem2proc_data  = $urandom;
                invalidate     = ($urandom_range(0, 19) == 0);
                step();
            end
        end
        invalidate     = 1'b0;
        mem2proc_ack   = 1'b0;
        mem2proc_valid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
